// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_BEQ = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// rtl/pipe_ctrl_perf.sv - saturating event counter used for pipeline performance statistics
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Performance counters are built only when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_write_addr_i,
    input  logic [1:0]       mem_pcsrc_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pipe_en_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timeout_q;

    logic lu;
    logic ms;
    logic redirect;
    logic freeze;

    assign lu = ex_mem_read_i && (ex_write_addr_i != REG_ZERO) &&
                ((ex_write_addr_i == id_rs_i) ||
                 (id_uses_rt_i && (ex_write_addr_i == id_rt_i)));
    assign ms       = dmem_req_i && !dmem_ready_i;
    assign redirect = (mem_pcsrc_i != PCSRC_SEQ);

    // A ready MEM_WAIT cycle behaves like RUN without the memory stall.
    assign freeze = (state == ERR) ||
                    ((state == MEM_WAIT) && !dmem_ready_i) ||
                    ((state == RUN) && ms);

    assign timeout_o = timeout_q;

    always_comb begin
        pipe_en_o      = 1'b1;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (rst_i) begin
            pipe_en_o      = 1'b0;
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (freeze) begin
            pipe_en_o      = 1'b0;
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
        end else if (redirect) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (lu) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_flush_o  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ms) begin
                        wait_cnt <= 8'd1;
                        state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready_i) begin
                        wait_cnt <= 8'd0;
                        state    <= RUN;
                    end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    timeout_q <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !rst_i && (freeze || (!redirect && lu));
    assign flush_inc = !rst_i && !freeze && redirect;

    pipe_ctrl_perf #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_ctrl_perf #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TB_CNT_W = 4;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [5:0] O_RST = 6'b000111;
    localparam logic [5:0] O_FRZ = 6'b000000;
    localparam logic [5:0] O_RDR = 6'b111111;
    localparam logic [5:0] O_LU  = 6'b100010;
    localparam logic [5:0] O_NRM = 6'b111000;

    logic                clk;
    logic                rst;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic                id_uses_rt;
    logic                ex_mem_read;
    logic [4:0]          ex_write_addr;
    logic [1:0]          mem_pcsrc;
    logic                dmem_req;
    logic                dmem_ready;
    logic                pipe_en;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_flush;
    logic                ex_mem_flush;
    logic                timeout;
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(TB_CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .id_uses_rt_i    (id_uses_rt),
        .ex_mem_read_i   (ex_mem_read),
        .ex_write_addr_i (ex_write_addr),
        .mem_pcsrc_i     (mem_pcsrc),
        .dmem_req_i      (dmem_req),
        .dmem_ready_i    (dmem_ready),
        .pipe_en_o       (pipe_en),
        .pc_write_o      (pc_write),
        .if_id_write_o   (if_id_write),
        .if_id_flush_o   (if_id_flush),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_flush_o  (ex_mem_flush),
        .timeout_o       (timeout),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mrd;
        logic [4:0] wa;
        logic [1:0] pcsrc;
        logic       req;
        logic       rdy;
        logic [5:0] o;
        logic       to;
    } vec_t;

    typedef struct {
        string               name;
        logic [5:0]          o;
        logic                to;
        logic [TB_CNT_W-1:0] sc;
        logic [TB_CNT_W-1:0] fc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [TB_CNT_W-1:0] stall_m = '0;
    logic [TB_CNT_W-1:0] flush_m = '0;

    function automatic vec_t mk(input string name, input logic r,
                                input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                input logic mrd, input logic [4:0] wa, input logic [1:0] pcs,
                                input logic req, input logic rdy,
                                input logic [5:0] o, input logic to);
        vec_t v;
        v.name = name; v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ur;
        v.mrd = mrd; v.wa = wa; v.pcsrc = pcs; v.req = req; v.rdy = rdy;
        v.o = o; v.to = to;
        return v;
    endfunction

    task automatic chk(input string what, input string name, input int idx,
                       input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s[%0d]: got %h expected %h", what, name, idx, got, exp);
        end
    endtask

    function automatic logic [TB_CNT_W-1:0] sat_inc(input logic [TB_CNT_W-1:0] c);
        return (c == {TB_CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = v.rst;
        id_rs         = v.rs;
        id_rt         = v.rt;
        id_uses_rt    = v.uses_rt;
        ex_mem_read   = v.mrd;
        ex_write_addr = v.wa;
        mem_pcsrc     = v.pcsrc;
        dmem_req      = v.req;
        dmem_ready    = v.rdy;
        e.name = v.name;
        e.o    = v.o;
        e.to   = v.to;
        e.sc   = PERF ? stall_m : '0;
        e.fc   = PERF ? flush_m : '0;
        sb.push_back(e);
        // The model's counters advance by what this cycle is expected to do.
        if (v.rst) begin
            stall_m = '0;
            flush_m = '0;
        end else begin
            if (!v.o[5] || (v.o == O_LU)) stall_m = sat_inc(stall_m);
            if (v.o == O_RDR) flush_m = sat_inc(flush_m);
        end
        @(negedge clk);
        e = sb.pop_front();
        chk("ctrl",      e.name, idx,
            {2'b00, pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush},
            {2'b00, e.o});
        chk("timeout",   e.name, idx, {7'd0, timeout}, {7'd0, e.to});
        chk("stall_cnt", e.name, idx, {4'd0, stall_cnt}, {4'd0, e.sc});
        chk("flush_cnt", e.name, idx, {4'd0, flush_cnt}, {4'd0, e.fc});
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_write_addr = '0; mem_pcsrc = PCSRC_SEQ; dmem_req = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //             name      rst rs     rt     ur   mrd  wa     pcsrc      req  rdy  out    to
        tbl.push_back(mk("reset",   1, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_RST, 0));
        tbl.push_back(mk("normal",  0, 5'd8, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_NRM, 0));
        tbl.push_back(mk("lu_rs",   0, 5'd8, 5'd0, 0, 1, 5'd8, PCSRC_SEQ, 0, 0, O_LU,  0));
        tbl.push_back(mk("lu_r0",   0, 5'd0, 5'd0, 1, 1, 5'd0, PCSRC_SEQ, 0, 0, O_NRM, 0));
        tbl.push_back(mk("lu_rt",   0, 5'd1, 5'd9, 1, 1, 5'd9, PCSRC_SEQ, 0, 0, O_LU,  0));
        tbl.push_back(mk("rt_nouse",0, 5'd1, 5'd9, 0, 1, 5'd9, PCSRC_SEQ, 0, 0, O_NRM, 0));
        tbl.push_back(mk("jr_lu",   0, 5'd8, 5'd0, 0, 1, 5'd8, PCSRC_JR,  0, 0, O_RDR, 0));
        tbl.push_back(mk("beq",     0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_BEQ, 0, 0, O_RDR, 0));
        tbl.push_back(mk("mw1",     0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 0, O_FRZ, 0));
        tbl.push_back(mk("mw2",     0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 0, O_FRZ, 0));
        tbl.push_back(mk("mw3",     0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 0, O_FRZ, 0));
        tbl.push_back(mk("mw_rdy",  0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 1, O_NRM, 0));
        tbl.push_back(mk("run_rdy", 0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 1, O_NRM, 0));
        tbl.push_back(mk("ms_j",    0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_J,   1, 0, O_FRZ, 0));
        tbl.push_back(mk("rdy_j",   0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_J,   1, 1, O_RDR, 0));
        tbl.push_back(mk("after_j", 0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_NRM, 0));
        // Reset in the middle of a memory wait.
        tbl.push_back(mk("rm_ms",   0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 0, O_FRZ, 0));
        tbl.push_back(mk("rm_rst",  1, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 0, O_RST, 0));
        tbl.push_back(mk("rm_run",  0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_NRM, 0));
        // Timeout after four unanswered wait edges, then a sticky freeze.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("to_wait", 0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 1, 0, O_FRZ, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk("to_err",  0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 1, O_FRZ, 1));
        tbl.push_back(mk("to_rst",  1, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_RST, 1));
        tbl.push_back(mk("to_run",  0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_NRM, 0));
        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk("sat_lu",  0, 5'd3, 5'd0, 0, 1, 5'd3, PCSRC_SEQ, 0, 0, O_LU,  0));
        tbl.push_back(mk("sat_chk", 0, 5'd0, 5'd0, 0, 0, 5'd0, PCSRC_SEQ, 0, 0, O_NRM, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        chk("sb_empty", "end", 0, 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
